// File: rtl/imem_load_ctrl_pkg.sv
// imem_load_ctrl_pkg: shared state encoding and default widths for the imem boot loader
package imem_load_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RELEASE, RUN} state_t;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_MAX_WORDS = 256;
  localparam int DEF_RST_HOLD = 4;
endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: packs bytes LSB-first into words; ports clk/rst, clear (restart), push (byte valid), flush (zero-pad partial), byte_in, emit (word ready), word
module imem_byte_packer #(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  flush,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic                  emit,
  output logic [DATA_WIDTH-1:0] word
);
  logic [1:0] lane, lane_nx;
  logic [DATA_WIDTH-1:0] acc;
  always_comb begin
    word = acc | (push ? DATA_WIDTH'(byte_in) << (BYTE_WIDTH * lane) : '0);
    lane_nx = lane + 2'(push);
    emit = (push && lane == 2'd3) || (flush && lane_nx != 2'd0);
  end
  // acc is cleared after every emit so unfilled upper bytes are always zero
  always_ff @(posedge clk) begin
    if (rst || clear || emit) begin
      lane <= '0;
      acc <= '0;
    end else if (push) begin
      lane <= lane_nx;
      acc <= word;
    end
  end
endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot loader packing a byte stream into imem words and sequencing core reset; ports clk/rst, load_start/byte_in/byte_valid/load_done in, imem write port, cpu_rst, busy, word_count, overflow out
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int RST_HOLD = DEF_RST_HOLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  input  logic                  load_done,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  overflow
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX = ADDR_WIDTH'(MAX_WORDS);
  state_t state, state_nx;
  logic [HW-1:0] hold;
  logic live, accept, flush, emit;
  logic [DATA_WIDTH-1:0] word;
  // load_start preempts everything, so a restart never lets a byte, flush or write through
  assign live = state == LOAD && !load_start;
  assign accept = live && byte_valid && word_count != MAX;
  assign flush = live && load_done;
  assign busy = state == LOAD || state == FLUSH || state == RELEASE;
  imem_byte_packer #(.BYTE_WIDTH(BYTE_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_pack (
    .clk(clk),
    .rst(rst),
    .clear(load_start),
    .push(accept),
    .flush(flush),
    .byte_in(byte_in),
    .emit(emit),
    .word(word)
  );
  always_comb
    state_nx = load_start ? LOAD :
               (state == LOAD && load_done) ? FLUSH :
               state == FLUSH ? RELEASE :
               (state == RELEASE && hold == HW'(RST_HOLD - 1)) ? RUN : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      imem_we <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_rst <= 1'b1;
      word_count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      hold <= state == RELEASE ? hold + 1'b1 : '0;
      cpu_rst <= state_nx != RUN;
      imem_we <= emit;
      if (emit) begin
        imem_waddr <= {word_count[ADDR_WIDTH-3:0], 2'b00};
        imem_wdata <= word;
      end
      word_count <= load_start ? '0 : word_count + ADDR_WIDTH'(emit);
      overflow <= load_start ? 1'b0 : overflow | (live && byte_valid && word_count == MAX);
    end
  end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: scoreboard bench for imem_load_ctrl (default depth plus a 2-word instance for overflow)
module tb_imem_load_ctrl;
  localparam int RST_HOLD = 4;
  logic clk = 0, rst = 1, ls = 0, bv = 0, ld = 0, ls2 = 0, bv2 = 0, ld2 = 0;
  logic [7:0] bin = 0;
  logic we, cpu_rst, busy, overflow, we2, cpu_rst2, busy2, overflow2;
  logic [15:0] waddr, wc, waddr2, wc2;
  logic [31:0] wdata, wdata2;
  logic [47:0] q[$], q2[$], got;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  imem_load_ctrl #(.RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .load_start(ls), .byte_in(bin), .byte_valid(bv), .load_done(ld),
    .imem_we(we), .imem_waddr(waddr), .imem_wdata(wdata), .cpu_rst(cpu_rst), .busy(busy),
    .word_count(wc), .overflow(overflow)
  );
  imem_load_ctrl #(.MAX_WORDS(2), .RST_HOLD(RST_HOLD)) dut_s (
    .clk(clk), .rst(rst), .load_start(ls2), .byte_in(bin), .byte_valid(bv2), .load_done(ld2),
    .imem_we(we2), .imem_waddr(waddr2), .imem_wdata(wdata2), .cpu_rst(cpu_rst2), .busy(busy2),
    .word_count(wc2), .overflow(overflow2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [7:0] b);
    bv = 1; bin = b; tick; bv = 0;
  endtask
  task automatic put2(input logic [7:0] b);
    bv2 = 1; bin = b; tick; bv2 = 0;
  endtask
  task automatic start;
    ls = 1; tick; ls = 0;
  endtask
  task automatic scoreboard_mon;
    forever begin
      @(negedge clk);
      if (we) begin
        checks++;
        got = {waddr, wdata};
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%h data=%h", waddr, wdata);
        end else if (got !== q[0]) begin
          failures++;
          $display("FAIL write actual=%h expected=%h", got, q[0]);
          void'(q.pop_front());
        end else void'(q.pop_front());
      end
      if (we2) begin
        checks++;
        got = {waddr2, wdata2};
        if (q2.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write_s addr=%h data=%h", waddr2, wdata2);
        end else if (got !== q2[0]) begin
          failures++;
          $display("FAIL write_s actual=%h expected=%h", got, q2[0]);
          void'(q2.pop_front());
        end else void'(q2.pop_front());
      end
    end
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 20 && (q.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    checks++;
    if (q.size() != 0 || q2.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d/%0d required=0", name, q.size(), q2.size());
    end
  endtask
  task automatic test_reset;
    rst = 1; tick; tick;
    checks += 7;
    if ({we, we2} !== 2'b00) begin failures++; $display("FAIL rst_we actual=%b required=00", {we, we2}); end
    if (waddr !== 16'h0) begin failures++; $display("FAIL rst_waddr actual=%h required=0", waddr); end
    if (wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata actual=%h required=0", wdata); end
    if ({cpu_rst, cpu_rst2} !== 2'b11) begin failures++; $display("FAIL rst_cpu_rst actual=%b required=11", {cpu_rst, cpu_rst2}); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b required=0", busy); end
    if (wc !== 16'h0) begin failures++; $display("FAIL rst_word_count actual=%0d required=0", wc); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow actual=%b required=0", overflow); end
    rst = 0; tick;
  endtask
  task automatic test_basic;
    int n;
    start;
    checks++;
    if (busy !== 1'b1 || cpu_rst !== 1'b1) begin failures++; $display("FAIL basic_busy actual=%b%b required=11", busy, cpu_rst); end
    put(8'h13); put(8'h05); put(8'h00);
    q.push_back({16'h0000, 32'h00000513}); put(8'h00);
    put(8'h93); put(8'h05); put(8'h10);
    q.push_back({16'h0004, 32'h00100593}); put(8'h00);
    ld = 1; tick; ld = 0;
    checks++;
    if (wc !== 16'd2) begin failures++; $display("FAIL basic_word_count actual=%0d required=2", wc); end
    n = 0;
    @(negedge clk);
    while (cpu_rst === 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks += 2;
    if (n != RST_HOLD + 1) begin failures++; $display("FAIL basic_hold actual=%0d required=%0d", n, RST_HOLD + 1); end
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_run_busy actual=%b required=0", busy); end
    drain("basic");
  endtask
  task automatic test_partial;
    start;
    put(8'hAA); put(8'hBB); put(8'hCC);
    q.push_back({16'h0000, 32'h00CCBBAA});
    ld = 1; tick; ld = 0;
    checks++;
    if (we !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL partial_flush_write actual=%b%b required=11", we, busy); end
    for (int i = 0; i < RST_HOLD + 3; i++) tick;
    checks += 2;
    if (wc !== 16'd1) begin failures++; $display("FAIL partial_word_count actual=%0d required=1", wc); end
    if (cpu_rst !== 1'b0) begin failures++; $display("FAIL partial_cpu_rst actual=%b required=0", cpu_rst); end
    drain("partial");
  endtask
  task automatic test_done_with_last;
    int n;
    start;
    put(8'h01); put(8'h02); put(8'h03);
    q.push_back({16'h0000, 32'h04030201});
    ld = 1; put(8'h04); ld = 0;
    @(negedge clk);
    n = 0;
    @(negedge clk);
    while (cpu_rst === 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks += 2;
    if (n != RST_HOLD) begin failures++; $display("FAIL last_hold actual=%0d required=%0d", n, RST_HOLD); end
    if (wc !== 16'd1) begin failures++; $display("FAIL last_word_count actual=%0d required=1", wc); end
    drain("last");
  endtask
  task automatic test_overflow;
    ls2 = 1; tick; ls2 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) q2.push_back({16'h0000, 32'h13121110});
      if (i == 7) q2.push_back({16'h0004, 32'h17161514});
      put2(8'(8'h10 + i));
    end
    checks++;
    if (overflow2 !== 1'b0) begin failures++; $display("FAIL ovf_early actual=%b required=0", overflow2); end
    for (int i = 8; i < 12; i++) put2(8'(8'h10 + i));
    tick;
    checks += 3;
    if (overflow2 !== 1'b1) begin failures++; $display("FAIL ovf_set actual=%b required=1", overflow2); end
    if (wc2 !== 16'd2) begin failures++; $display("FAIL ovf_word_count actual=%0d required=2", wc2); end
    if (waddr2 !== 16'h0004) begin failures++; $display("FAIL ovf_waddr actual=%h required=0004", waddr2); end
    ld2 = 1; tick; ld2 = 0;
    ls2 = 1; tick; ls2 = 0;
    checks++;
    if (overflow2 !== 1'b0) begin failures++; $display("FAIL ovf_clear actual=%b required=0", overflow2); end
    drain("ovf");
  endtask
  task automatic test_restart_run;
    int n;
    logic [31:0] w;
    start;
    for (int i = 0; i < 5; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(8'h20 + 4 * i + k);
      q.push_back({16'(4 * i), w});
      for (int k = 0; k < 4; k++) put(w[8*k +: 8]);
    end
    ld = 1; tick; ld = 0;
    n = 0;
    while (cpu_rst !== 1'b0 && n < 50) begin n++; @(negedge clk); end
    checks += 2;
    if (cpu_rst !== 1'b0) begin failures++; $display("FAIL run_reached actual=%b required=0", cpu_rst); end
    if (wc !== 16'd5) begin failures++; $display("FAIL run_word_count actual=%0d required=5", wc); end
    ls = 1; tick; ls = 0;
    checks += 2;
    if (cpu_rst !== 1'b1) begin failures++; $display("FAIL restart_cpu_rst actual=%b required=1", cpu_rst); end
    if (wc !== 16'd0) begin failures++; $display("FAIL restart_word_count actual=%0d required=0", wc); end
    put(8'hDE); put(8'hAD); put(8'hBE);
    q.push_back({16'h0000, 32'hEFBEADDE}); put(8'hEF);
    drain("restart");
    checks++;
    if (wc !== 16'd1) begin failures++; $display("FAIL restart_count1 actual=%0d required=1", wc); end
  endtask
  task automatic test_rst_mid;
    start;
    put(8'h11); put(8'h22);
    rst = 1; tick; rst = 0;
    checks += 3;
    if (we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle actual=%b%b required=00", we, busy); end
    if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rstmid_cpu_rst actual=%b required=1", cpu_rst); end
    if (wc !== 16'd0) begin failures++; $display("FAIL rstmid_word_count actual=%0d required=0", wc); end
    put(8'h55); ld = 1; tick; ld = 0; tick; tick;
    start;
    put(8'h31); put(8'h32); put(8'h33);
    q.push_back({16'h0000, 32'h34333231}); put(8'h34);
    ld = 1; tick; ld = 0;
    drain("rstmid");
  endtask
  initial begin
    fork
      scoreboard_mon;
    join_none
    test_reset;
    test_basic;
    test_partial;
    test_done_with_last;
    test_overflow;
    test_restart_run;
    test_rst_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
